// File: rtl/cpu_fpu_add_arbiter_pkg.sv
// ============================================================================
//  Module   : cpu_fpu_add_arbiter_pkg
//  Purpose  : Shared types and constants for the FPU adder arbiter and the
//             round-robin picker.
//  Contents : state_t          arbiter FSM state encoding
//             c_FP_WIDTH       IEEE-754 single-precision word width
//             c_FP_SIGN_BIT    sign bit position in a single-precision word
//             c_DEF_NUM_PORTS  default number of requesters
//             c_DEF_TIMEOUT    default watchdog limit in WAIT cycles
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_fpu_add_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int c_FP_WIDTH      = 32;
    localparam int c_FP_SIGN_BIT   = 31;
    localparam int c_DEF_NUM_PORTS = 2;
    // The FPU worst case is about 300 cycles; 512 leaves comfortable margin.
    localparam int c_DEF_TIMEOUT   = 512;

endpackage

`default_nettype wire

// File: rtl/cpu_fpu_add_arbiter_picker.sv
// ============================================================================
//  Module   : cpu_rr_picker
//  Purpose  : Combinational round-robin selector. Returns the first eligible
//             requester at or after the pointer, wrapping modulo NUM_PORTS.
//  Ports    : i_eligible  in   NUM_PORTS  per-port eligibility
//             i_pointer   in   IDX_W      highest-priority index this cycle
//             o_valid     out  1          at least one port is eligible
//             o_index     out  IDX_W      selected port index
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_rr_picker
    import cpu_fpu_add_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = c_DEF_NUM_PORTS,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_eligible,
    input  logic [IDX_W-1:0]     i_pointer,
    output logic                 o_valid,
    output logic [IDX_W-1:0]     o_index
);

    logic [IDX_W:0] w_pos;

    // Walk the offsets from farthest to nearest so that the nearest eligible
    // port (lowest offset from the pointer) is the last one written and wins.
    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        w_pos   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            w_pos = {1'b0, i_pointer} + (IDX_W + 1)'(i);
            if (w_pos >= (IDX_W + 1)'(NUM_PORTS)) begin
                w_pos = w_pos - (IDX_W + 1)'(NUM_PORTS);
            end
            if (i_eligible[w_pos[IDX_W-1:0]]) begin
                o_valid = 1'b1;
                o_index = w_pos[IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_fpu_add_arbiter.sv
// ============================================================================
//  Module   : cpu_fpu_add_arbiter
//  Purpose  : Shares one single-precision FPU adder between NUM_PORTS
//             requesters with round-robin arbitration. Subtraction is done by
//             flipping the sign of op2 at grant. One result register per
//             port; a watchdog aborts an FPU operation that never completes.
//  Ports    : i_clock        in   1              rising-edge clock
//             i_reset_n      in   1              async assert, active-low
//             i_req          in   NUM_PORTS      level request, held to ready
//             i_sub          in   NUM_PORTS      1 = op1 - op2
//             i_op1, i_op2   in   32*NUM_PORTS   port k at [32k+31:32k]
//             o_ready        out  NUM_PORTS      result valid until req drops
//             o_result       out  32*NUM_PORTS   per-port result register
//             o_busy         out  1              FPU operation in flight
//             o_error        out  1              sticky watchdog abort flag
//             o_fpu_request  out  1              to FPU request
//             o_fpu_op1/op2  out  32             to FPU operands
//             i_fpu_ready    in   1              from FPU ready
//             i_fpu_result   in   32             from FPU result
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_fpu_add_arbiter
    import cpu_fpu_add_arbiter_pkg::*;
#(
    parameter int NUM_PORTS      = c_DEF_NUM_PORTS,
    parameter int TIMEOUT_CYCLES = c_DEF_TIMEOUT
) (
    input  logic                            i_clock,
    input  logic                            i_reset_n,
    input  logic [NUM_PORTS-1:0]            i_req,
    input  logic [NUM_PORTS-1:0]            i_sub,
    input  logic [c_FP_WIDTH*NUM_PORTS-1:0] i_op1,
    input  logic [c_FP_WIDTH*NUM_PORTS-1:0] i_op2,
    output logic [NUM_PORTS-1:0]            o_ready,
    output logic [c_FP_WIDTH*NUM_PORTS-1:0] o_result,
    output logic                            o_busy,
    output logic                            o_error,
    output logic                            o_fpu_request,
    output logic [c_FP_WIDTH-1:0]           o_fpu_op1,
    output logic [c_FP_WIDTH-1:0]           o_fpu_op2,
    input  logic                            i_fpu_ready,
    input  logic [c_FP_WIDTH-1:0]           i_fpu_result
);

    localparam int c_IDX_W = $clog2(NUM_PORTS);
    localparam int c_WD_W  = $clog2(TIMEOUT_CYCLES);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic [c_IDX_W-1:0]     r_ptr;
    logic [c_IDX_W-1:0]     r_grant;
    logic [NUM_PORTS-1:0]   r_done;
    logic [c_FP_WIDTH-1:0]  r_result [NUM_PORTS];
    logic [c_FP_WIDTH-1:0]  r_op1;
    logic [c_FP_WIDTH-1:0]  r_op2;
    logic                   r_error;
    logic [c_WD_W-1:0]      r_wd_count;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    state_t                 w_state_next;
    logic [NUM_PORTS-1:0]   w_eligible;
    logic                   w_pick_valid;
    logic [c_IDX_W-1:0]     w_pick_idx;
    logic                   w_grant_fire;
    logic                   w_capture;
    logic                   w_timeout;
    logic                   w_wd_clear;
    logic                   w_wd_step;
    logic [c_FP_WIDTH-1:0]  w_op1_arr [NUM_PORTS];
    logic [c_FP_WIDTH-1:0]  w_op2_arr [NUM_PORTS];

    generate
        for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
            assign w_op1_arr[k]                      = i_op1[c_FP_WIDTH*k +: c_FP_WIDTH];
            assign w_op2_arr[k]                      = i_op2[c_FP_WIDTH*k +: c_FP_WIDTH];
            assign o_result[c_FP_WIDTH*k +: c_FP_WIDTH] = r_result[k];
        end
    endgenerate

    // A port still holding its ready is not eligible, so it cannot be
    // served twice for one request.
    assign w_eligible = i_req & ~r_done;

    cpu_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (c_IDX_W)
    ) u_picker (
        .i_eligible (w_eligible),
        .i_pointer  (r_ptr),
        .o_valid    (w_pick_valid),
        .o_index    (w_pick_idx)
    );

    assign o_ready   = r_done;
    assign o_error   = r_error;
    assign o_fpu_op1 = r_op1;
    assign o_fpu_op2 = r_op2;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and decoded outputs. The FPU request is decoded
    // from the state so that an asynchronous reset drops it immediately.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_grant_fire  = 1'b0;
        w_capture     = 1'b0;
        w_timeout     = 1'b0;
        w_wd_clear    = 1'b0;
        w_wd_step     = 1'b0;
        o_fpu_request = 1'b0;
        o_busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Never start while the FPU is still showing a stale ready.
                if (w_pick_valid && !i_fpu_ready) begin
                    w_grant_fire = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_fpu_request = 1'b1;
                o_busy        = 1'b1;
                w_wd_clear    = 1'b1;
                w_state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                o_fpu_request = 1'b1;
                o_busy        = 1'b1;
                if (i_fpu_ready) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RELEASE;
                end else if (r_wd_count == c_WD_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_RELEASE;
                end else begin
                    w_wd_step = 1'b1;
                end
            end
            ST_RELEASE: begin
                o_busy = 1'b1;
                if (!i_fpu_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: grant, operands, results, done flags, watchdog, error
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ptr      <= '0;
            r_grant    <= '0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_done     <= '0;
            r_error    <= 1'b0;
            r_wd_count <= '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                r_result[k] <= '0;
            end
        end else begin
            if (w_grant_fire) begin
                r_grant <= w_pick_idx;
                r_op1   <= w_op1_arr[w_pick_idx];
                r_op2   <= {w_op2_arr[w_pick_idx][c_FP_SIGN_BIT] ^ i_sub[w_pick_idx],
                            w_op2_arr[w_pick_idx][c_FP_SIGN_BIT-1:0]};
                if (w_pick_idx == c_IDX_W'(NUM_PORTS - 1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_pick_idx + 1'b1;
                end
            end

            // A requester that gave up mid-operation gets neither the
            // result nor a ready.
            if (w_capture && i_req[r_grant]) begin
                r_result[r_grant] <= i_fpu_result;
            end

            for (int k = 0; k < NUM_PORTS; k++) begin
                r_done[k] <= (r_done[k] & i_req[k])
                           | (w_capture && (r_grant == c_IDX_W'(k)) && i_req[k]);
            end

            if (w_wd_clear) begin
                r_wd_count <= '0;
            end else if (w_wd_step) begin
                r_wd_count <= r_wd_count + 1'b1;
            end

            if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
